// File: rtl/mulseq.sv
// Sequential integer multiplier retiring BPC multiplier bits per cycle.
// Covers MUL/MULH/MULHSU/MULHU and the 32-bit MULW word form on XLEN=64.
module mulseq #(
    parameter int XLEN = 64,
    parameter int BPC  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    input  logic [2:0]      Funct3E,
    input  logic            WE,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [1:0]      state_o
);
    localparam int N  = XLEN / BPC;
    localparam int NW = 32 / BPC;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2*XLEN:0]   acc_q;
    logic [XLEN-1:0]   a_q, b_q;
    logic [1:0]        f_q;
    logic              w_q;
    logic              busy_q, done_q;
    logic [XLEN-1:0]   res_q;

    logic              accept, w_in;
    logic [XLEN-1:0]   a_in, b_in;
    logic [XLEN+BPC-1:0] pp;
    logic [XLEN+BPC:0] sum;
    logic [2*XLEN:0]   acc_d;
    logic [XLEN-1:0]   hi_s, wres, res_d;
    logic              a_neg, b_neg;

    // Handshake: a request is taken on an edge with StartE=1, FlushE=0 and
    // the FSM in IDLE or DONE; StartE at any other time is dropped, not queued.
    assign accept = StartE && !FlushE && (state_q == IDLE || state_q == DONE);
    assign w_in   = WE && (XLEN == 64);
    assign a_in   = w_in ? (SrcAE & XLEN'(64'hFFFF_FFFF)) : SrcAE;
    assign b_in   = w_in ? (SrcBE & XLEN'(64'hFFFF_FFFF)) : SrcBE;

    // Unsigned radix-2^BPC step: add A*digit into the high half, shift right.
    always_comb begin
        pp    = {{BPC{1'b0}}, a_q} * {{XLEN{1'b0}}, acc_q[BPC-1:0]};
        sum   = {{BPC{1'b0}}, acc_q[2*XLEN:XLEN]} + {1'b0, pp};
        acc_d = {sum, acc_q[XLEN-1:BPC]};
    end

    // Signed high halves come from the unsigned product minus the operand
    // weighted by the other operand's sign bit.
    always_comb begin
        a_neg = a_q[XLEN-1] && (f_q == 2'b01 || f_q == 2'b10);
        b_neg = b_q[XLEN-1] && (f_q == 2'b01);
        hi_s  = acc_q[2*XLEN-1:XLEN] - (a_neg ? b_q : '0) - (b_neg ? a_q : '0);
        wres  = {XLEN{acc_q[XLEN-1]}};
        wres[31:0] = acc_q[XLEN-1 -: 32];
        if (w_q)               res_d = wres;
        else if (f_q == 2'b00) res_d = acc_q[XLEN-1:0];
        else                   res_d = hi_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            w_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else if (FlushE) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= a_in;
                        b_q     <= b_in;
                        f_q     <= Funct3E[1:0];
                        w_q     <= w_in;
                        acc_q   <= {{(XLEN+1){1'b0}}, b_in};
                        cnt_q   <= w_in ? CW'(NW - 1) : CW'(N - 1);
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    if (cnt_q == '0) state_q <= FIX;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                FIX: begin
                    res_q   <= res_d;
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Result  = res_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_mulseq.sv
// Directed bench for mulseq at XLEN=64, BPC=4 (N=16): products, latency,
// flush, back-to-back issue and asynchronous reset behaviour.
module tb_mulseq;
    logic        clk = 1'b0;
    logic        reset;
    logic        StartE, FlushE, WE;
    logic [63:0] SrcAE, SrcBE;
    logic [2:0]  Funct3E;
    logic        Busy, Done;
    logic [63:0] Result;
    logic [1:0]  state_o;

    int checks   = 0;
    int failures = 0;

    mulseq #(.XLEN(64), .BPC(4)) dut (
        .clk(clk), .reset(reset), .StartE(StartE), .FlushE(FlushE),
        .SrcAE(SrcAE), .SrcBE(SrcBE), .Funct3E(Funct3E), .WE(WE),
        .Busy(Busy), .Done(Done), .Result(Result), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp_v);
        end
    endtask

    // Issues one request, then waits (bounded) for Done and checks latency,
    // Busy over the whole operation and the product. Returns in the DONE cycle.
    task automatic run_op(input string tag, input logic [2:0] f, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_v, input int exp_lat, input logic pulse);
        int   lat;
        logic busy_ok;
        SrcAE = a; SrcBE = b; Funct3E = f; WE = w; StartE = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0;
        SrcAE = {$urandom, $urandom};
        SrcBE = {$urandom, $urandom};
        Funct3E = 3'($urandom_range(0, 3));
        WE = 1'($urandom_range(0, 1));
        lat = 0;
        busy_ok = Busy;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (Done) begin
                lat = k;
                break;
            end
            busy_ok &= Busy;
            if (pulse && k == 5) begin
                StartE = 1'b1;
                SrcAE  = 64'hFFFF_0000_FFFF_0000;
                SrcBE  = 64'h0000_FFFF_0000_FFFF;
            end
            if (pulse && k == 6) StartE = 1'b0;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy_during"}, {63'd0, busy_ok}, 64'd1);
        chk({tag, "_busy_in_done"}, {63'd0, Busy}, 64'd0);
        chk({tag, "_result"}, Result, exp_v);
    endtask

    initial begin
        reset = 1'b0; StartE = 1'b0; FlushE = 1'b0; WE = 1'b0;
        SrcAE = '0; SrcBE = '0; Funct3E = 3'b000;
        #12;
        chk("reset_busy", {63'd0, Busy}, 64'd0);
        chk("reset_done", {63'd0, Done}, 64'd0);
        chk("reset_result", Result, 64'd0);
        chk("reset_state", {62'd0, state_o}, 64'd0);
        #11 reset = 1'b1;

        // First edge after release must accept.
        run_op("mul_ones", 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h1, 17, 1'b0);
        @(posedge clk); #1;
        chk("done_one_cycle", {63'd0, Done}, 64'd0);
        chk("idle_after_done", {62'd0, state_o}, 64'd0);

        run_op("mulh_min", 3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
               64'h4000_0000_0000_0000, 17, 1'b0);
        run_op("mulhu_ones", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 17, 1'b0);
        run_op("mulhsu_ones", 3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0);
        run_op("mul_neg3x5", 3'b000, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFF1, 17, 1'b0);
        run_op("mulh_neg3x5", 3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
               64'hFFFF_FFFF_FFFF_FFFF, 17, 1'b0);
        run_op("mulw", 3'b000, 1'b1, 64'h7FFF_FFFF, 64'h2,
               64'hFFFF_FFFF_FFFF_FFFE, 9, 1'b0);
        run_op("mulw_upper_ignored", 3'b001, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF,
               64'h1234_5678_0000_0002, 64'hFFFF_FFFF_FFFF_FFFE, 9, 1'b0);

        // Flush on the 5th RUN edge.
        @(posedge clk); #1;
        SrcAE = 64'd3; SrcBE = 64'd7; Funct3E = 3'b000; WE = 1'b0; StartE = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (4) @(posedge clk);
        #1 FlushE = 1'b1;
        @(posedge clk); #1;
        FlushE = 1'b0;
        chk("flush_busy", {63'd0, Busy}, 64'd0);
        chk("flush_done", {63'd0, Done}, 64'd0);
        chk("flush_result_kept", Result, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("after_flush", 3'b000, 1'b0, 64'h1234_5678, 64'h10,
               64'h1_2345_6780, 17, 1'b0);

        // Back-to-back: the next request is issued in the DONE cycle.
        run_op("b2b_first", 3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 17, 1'b0);
        run_op("b2b_second", 3'b000, 1'b0, 64'd6, 64'd7, 64'd42, 17, 1'b1);

        // Asynchronous reset between edges in the middle of RUN.
        @(posedge clk); #1;
        SrcAE = 64'd9; SrcBE = 64'd9; Funct3E = 3'b000; WE = 1'b0; StartE = 1'b1;
        @(posedge clk); #1;
        StartE = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_rst_busy", {63'd0, Busy}, 64'd0);
        chk("async_rst_done", {63'd0, Done}, 64'd0);
        chk("async_rst_result", Result, 64'd0);
        @(posedge clk); #3 reset = 1'b1;
        run_op("after_reset", 3'b000, 1'b0, 64'd3, 64'd5, 64'hF, 17, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
